// File: rtl/show_corrode_pkg.sv
// Shared constants and types for the eroded-bitmap read-side scanner.
package show_corrode_pkg;
    localparam int IMG_W      = 128;
    localparam int IMG_H      = 64;
    localparam int ADDR_W     = 13;
    localparam int PIPE_DEPTH = 3;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        logic vs;
        logic hs;
        logic de;
        rgb_t rgb;
    } vbus_t;
endpackage

// File: rtl/show_corrode_reader_video_delay_line.sv
// Fixed-depth delay for the video bus; clears to an all-zero (blank) bus on reset.
module video_delay_line
    import show_corrode_pkg::*;
#(
    parameter int N = PIPE_DEPTH
) (
    input  logic  clk,
    input  logic  rst_n,
    input  vbus_t bus_i,
    output vbus_t bus_o
);
    vbus_t [N:1] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[1] <= bus_i;
            for (int i = 2; i <= N; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign bus_o = pipe_q[N];
endmodule

// File: rtl/show_corrode_reader.sv
// Scans the video timing, reads the eroded bitmap inside a fixed window and recolours it.
// Optional 1-pixel FG border around the window: define SHOW_CORRODE_BORDER_EN.
module show_corrode_reader
    import show_corrode_pkg::*;
#(
    parameter int          IMG_W      = show_corrode_pkg::IMG_W,
    parameter int          IMG_H      = show_corrode_pkg::IMG_H,
    parameter int          SCALE_LOG2 = 1,
    parameter int          WIN_X      = 100,
    parameter int          WIN_Y      = 100,
    parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB     = 24'h000000,
    parameter logic        VS_POL     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vs,
    input  logic              in_hs,
    input  logic              in_de,
    input  logic [23:0]       in_rgb,
    input  logic              overlay_en,
    output logic [ADDR_W-1:0] ram_adb,
    output logic              ram_ceb,
    output logic              ram_oce,
    output logic              ram_resetb,
    input  logic              ram_dout,
    output logic              out_vs,
    output logic              out_hs,
    output logic              out_de,
    output logic [23:0]       out_rgb
);
    localparam logic [11:0] WIN_WPX = 12'(IMG_W << SCALE_LOG2);
    localparam logic [10:0] WIN_HPX = 11'(IMG_H << SCALE_LOG2);

    logic [11:0]       x_cnt_q, x_cnt_d, dx;
    logic [10:0]       y_cnt_q, y_cnt_d, dy;
    logic              de_q, vs_act_q, frame_ok_q, ovl_act_q;
    logic              vs_act, vs_lead, in_win, in_bdr, dout_q;
    logic [ADDR_W-1:0] rd_addr, ram_adb_q;
    logic              ram_ceb_q;
    logic [PIPE_DEPTH:1] win_pipe_q, bdr_pipe_q;
    vbus_t             vin, vdly;

    assign vs_act  = (in_vs == VS_POL);
    assign vs_lead = vs_act & ~vs_act_q;

    always_comb begin
        x_cnt_d = in_de ? x_cnt_q + 12'd1 : 12'd0;
        y_cnt_d = y_cnt_q;
        if (vs_lead)
            y_cnt_d = '0;
        else if (de_q && !in_de && y_cnt_q != '1)
            y_cnt_d = y_cnt_q + 11'd1;
    end

    // Unsigned offsets: positions left of / above the window wrap large and fail the compare.
    assign dx      = x_cnt_q - 12'(WIN_X);
    assign dy      = y_cnt_q - 11'(WIN_Y);
    assign in_win  = in_de & frame_ok_q & ovl_act_q & (dx < WIN_WPX) & (dy < WIN_HPX);
    assign rd_addr = ADDR_W'(int'(dy >> SCALE_LOG2) * IMG_W + int'(dx >> SCALE_LOG2));

`ifdef SHOW_CORRODE_BORDER_EN
    logic [11:0] ex;
    logic [10:0] ey;
    assign ex     = x_cnt_q - 12'(WIN_X - 1);
    assign ey     = y_cnt_q - 11'(WIN_Y - 1);
    assign in_bdr = in_de & frame_ok_q & ovl_act_q
                  & (ex <= WIN_WPX + 12'd1) & (ey <= WIN_HPX + 11'd1)
                  & ((ex == 12'd0) | (ex == WIN_WPX + 12'd1)
                  |  (ey == 11'd0) | (ey == WIN_HPX + 11'd1));
`else
    assign in_bdr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            de_q       <= 1'b0;
            vs_act_q   <= 1'b0;
            frame_ok_q <= 1'b0;
            ovl_act_q  <= 1'b0;
            ram_adb_q  <= '0;
            ram_ceb_q  <= 1'b0;
            win_pipe_q <= '0;
            bdr_pipe_q <= '0;
            dout_q     <= 1'b0;
        end else begin
            x_cnt_q  <= x_cnt_d;
            y_cnt_q  <= y_cnt_d;
            de_q     <= in_de;
            vs_act_q <= vs_act;
            if (vs_lead) begin
                frame_ok_q <= 1'b1;
                ovl_act_q  <= overlay_en;
            end
            ram_ceb_q <= in_win;
            // Address is held outside the window so the RAM bus stays quiet.
            if (in_win) ram_adb_q <= rd_addr;
            win_pipe_q <= {win_pipe_q[PIPE_DEPTH-1:1], in_win};
            bdr_pipe_q <= {bdr_pipe_q[PIPE_DEPTH-1:1], in_bdr};
            dout_q     <= ram_dout;
        end
    end

    assign vin = '{vs: in_vs, hs: in_hs, de: in_de, rgb: in_rgb};

    video_delay_line #(.N(PIPE_DEPTH)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_i (vin),
        .bus_o (vdly)
    );

    assign ram_adb    = ram_adb_q;
    assign ram_ceb    = ram_ceb_q;
    assign ram_oce    = 1'b1;
    assign ram_resetb = 1'b0;

    assign out_vs  = vdly.vs;
    assign out_hs  = vdly.hs;
    assign out_de  = vdly.de;
    assign out_rgb = bdr_pipe_q[PIPE_DEPTH] ? FG_RGB :
                     win_pipe_q[PIPE_DEPTH] ? (dout_q ? FG_RGB : BG_RGB) : vdly.rgb;
endmodule

// File: tb/tb_show_corrode_reader.sv
// Randomized scoreboard bench for show_corrode_reader with a pixel-level reference model.
module tb_show_corrode_reader;
    localparam int          WX  = 8;
    localparam int          WY  = 4;
    localparam int          SC  = 2;
    localparam int          WWP = 128 * SC;
    localparam int          WHP = 64 * SC;
    localparam bit          VSP = 1'b1;
    localparam logic [23:0] FG  = 24'hFFFFFF;
    localparam logic [23:0] BG  = 24'h000000;
    localparam int          HB  = 6;
    localparam int          ACT = WX + WWP + 8;

    typedef struct {
        int          tag;
        logic        vs, hs, de;
        logic [23:0] rgb;
    } vexp_t;

    typedef struct {
        int          tag;
        logic        ceb;
        logic [12:0] adb;
    } aexp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_vs = 1'b0, in_hs = 1'b0, in_de = 1'b0, overlay_en = 1'b0;
    logic [23:0] in_rgb = '0;
    logic [12:0] ram_adb;
    logic        ram_ceb, ram_oce, ram_resetb;
    logic        ram_dout = 1'b0;
    logic        out_vs, out_hs, out_de;
    logic [23:0] out_rgb;

    bit          mem [0:8191];
    vexp_t       vq[$];
    aexp_t       aq[$];
    int          cyc = 0;
    int          n_cmp = 0, n_bad = 0;
    bit          m_ok = 0, m_ovl = 0, m_vsprev = 0;
    logic [12:0] m_addr = '0;

    show_corrode_reader #(.SCALE_LOG2(1), .WIN_X(WX), .WIN_Y(WY), .VS_POL(VSP)) dut (
        .clk(clk), .rst_n(rst_n), .in_vs(in_vs), .in_hs(in_hs), .in_de(in_de),
        .in_rgb(in_rgb), .overlay_en(overlay_en), .ram_adb(ram_adb), .ram_ceb(ram_ceb),
        .ram_oce(ram_oce), .ram_resetb(ram_resetb), .ram_dout(ram_dout),
        .out_vs(out_vs), .out_hs(out_hs), .out_de(out_de), .out_rgb(out_rgb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bypass-mode synchronous RAM, one-cycle read.
    always @(posedge clk) if (ram_ceb) ram_dout <= mem[ram_adb];

    // Monitor: output seen in a cycle is compared with whatever the scoreboard tagged for it.
    always @(negedge clk) begin
        while (vq.size() > 0 && vq[0].tag <= cyc) begin
            vexp_t e;
            e = vq.pop_front();
            n_cmp++;
            if (e.tag != cyc) begin
                n_bad++;
                $display("FAIL video_lost: tag %0d unchecked at cycle %0d", e.tag, cyc);
            end else if ({out_vs, out_hs, out_de, out_rgb} !== {e.vs, e.hs, e.de, e.rgb}) begin
                n_bad++;
                $display("FAIL video cyc %0d: got vs%b hs%b de%b rgb %h, want vs%b hs%b de%b rgb %h",
                         cyc, out_vs, out_hs, out_de, out_rgb, e.vs, e.hs, e.de, e.rgb);
            end
        end
        while (aq.size() > 0 && aq[0].tag <= cyc) begin
            aexp_t a;
            a = aq.pop_front();
            n_cmp++;
            if (a.tag != cyc) begin
                n_bad++;
                $display("FAIL ram_lost: tag %0d unchecked at cycle %0d", a.tag, cyc);
            end else if ({ram_ceb, ram_adb, ram_oce, ram_resetb} !== {a.ceb, a.adb, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL ram cyc %0d: got ceb%b adb %0d oce%b rstb%b, want ceb%b adb %0d oce1 rstb0",
                         cyc, ram_ceb, ram_adb, ram_oce, ram_resetb, a.ceb, a.adb);
            end
        end
    end

    function automatic vexp_t zv(input int tag);
        vexp_t v;
        v.tag = tag; v.vs = 0; v.hs = 0; v.de = 0; v.rgb = '0;
        return v;
    endfunction

    // One input cycle: the model decides what this pixel should become, 3 cycles later.
    task automatic drive(input logic vs, input logic hs, input logic de,
                         input logic [23:0] rgb, input int x, input int y);
        vexp_t v;
        aexp_t a;
        bit    act, win, bdr;
        in_vs = vs; in_hs = hs; in_de = de; in_rgb = rgb;
        act = de && m_ok && m_ovl;
        win = act && x >= WX && x < WX + WWP && y >= WY && y < WY + WHP;
        bdr = 0;
`ifdef SHOW_CORRODE_BORDER_EN
        bdr = act && !win && x >= WX - 1 && x <= WX + WWP && y >= WY - 1 && y <= WY + WHP;
`endif
        if (win) m_addr = 13'(((y - WY) / SC) * 128 + (x - WX) / SC);
        v.tag = cyc + 3; v.vs = vs; v.hs = hs; v.de = de;
        v.rgb = win ? (mem[m_addr] ? FG : BG) : bdr ? FG : rgb;
        a.tag = cyc + 1; a.ceb = win; a.adb = m_addr;
        vq.push_back(v);
        aq.push_back(a);
        if (vs == VSP && !m_vsprev) begin
            m_ok  = 1;
            m_ovl = overlay_en;
        end
        m_vsprev = (vs == VSP);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        aexp_t a;
        rst_n = 1'b0;
        vq.delete();
        aq.delete();
        in_vs = 0; in_hs = 0; in_de = 0; in_rgb = '0;
        m_ok = 0; m_ovl = 0; m_vsprev = 0; m_addr = '0;
        a.ceb = 0; a.adb = '0;
        for (int i = 0; i < n; i++) begin
            vq.push_back(zv(cyc));
            a.tag = cyc; aq.push_back(a);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) vq.push_back(zv(cyc + i));
        a.tag = cyc; aq.push_back(a);
    endtask

    task automatic frame(input int nlines, input bit ovl, input int tog_line, input int rst_line);
        int w;
        overlay_en = ovl;
        w = $urandom_range(1, 4);
        for (int i = 0; i < w; i++) drive(VSP, $urandom_range(0, 1), 0, 24'($urandom), -1, -1);
        for (int i = 0; i < 3; i++) drive(!VSP, 0, 0, 24'($urandom), -1, -1);
        for (int l = 0; l < nlines; l++) begin
            int hw;
            if (l == tog_line) overlay_en = !ovl;
            hw = $urandom_range(1, 3);
            for (int i = 0; i < HB; i++) drive(!VSP, i < hw, 0, 24'($urandom), -1, -1);
            for (int x = 0; x < ACT; x++) begin
                if (l == rst_line && x == 50) do_reset(3);
                drive(!VSP, 0, 1, 24'($urandom), x, l);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = (a < 128) ? a[0] : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        do_reset(4);
        frame(WY + WHP + 4, 1, -1, -1);  // full window, row 0 alternates FG/BG, last address 8191
        frame(12, 1, 6, -1);             // overlay dropped mid-frame: still overlaid
        frame(10, 0, -1, -1);            // pure passthrough, no RAM reads
        frame(12, 1, -1, 7);             // reset mid-active-line
        frame(10, 1, -1, -1);            // overlay returns after the next vs edge
        for (int i = 0; i < 6; i++) drive(!VSP, 0, 0, 24'($urandom), -1, -1);
        n_cmp++;
        if (vq.size() > 3 || aq.size() > 1) begin
            n_bad++;
            $display("FAIL drain: %0d video / %0d ram expectations left, want <=3 / <=1",
                     vq.size(), aq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
